serial_magnitude_comparator: RTL
================================

# serial_magnitude_comparator

Sequential MSB-first magnitude comparator controller for the processor datapath. It latches two WIDTH-bit operands on a start handshake and walks them two bits per cycle through a cascaded 2-bit compare stage, carrying equal/greater state between slices. It terminates early once the result is decided and reports equal/greater/less with a one-cycle done pulse. Branch/compare logic uses it where a full-width combinational comparator is too large.

## Interface
- WIDTH, 32: operand width; must be even and ≥ 2; slice count S = WIDTH/2
- SIGNED, 0: 1 = two's-complement compare, 0 = unsigned
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; accepted only in IDLE
- abort  input  1  cancel in-flight compare; no done is produced
- A  input  WIDTH  operand A; sampled on the accepted start edge
- B  input  WIDTH  operand B; sampled on the accepted start edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when result is valid
- EQ  output  1  A == B
- GT  output  1  A > B
- LT  output  1  A < B
- slices  output  $clog2(S+1)  number of slices evaluated in the last compare

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, EQ=0, GT=0, LT=0, slices=0; internal eq_r=1, gt_r=0, idx=S-1.
- IDLE, start=1:
  - Latch A and B; set eq_r=1, gt_r=0, idx=S-1, count=0.
  - Go to RUN. EQ/GT/LT/slices keep their old values until the next done.
- RUN, each edge:
  - Slice a = A[2idx+1:2idx], b = B[2idx+1:2idx].
  - When SIGNED=1 and idx=S-1, invert bit 1 of both a and b before comparing.
  - eq_n = eq_r & (a==b); gt_n = gt_r | (eq_r & (a>b)); count += 1.
  - If idx==0 or eq_n==0: go to DONE.
  - Otherwise idx -= 1 and stay in RUN.
- DONE, one cycle:
  - done=1; EQ=eq_r, GT=gt_r, LT=~eq_r&~gt_r, slices=count. Outputs are registered on the RUN→DONE edge.
  - Next state is IDLE. A start in DONE is ignored.
- Result outputs hold until the next done. Exactly one of EQ/GT/LT is high after the first done; all are 0 before it.
- start while busy is ignored. It is not queued.
- abort:
  - In RUN or DONE, go to IDLE on the next edge. Any pending done is suppressed. Result outputs are unchanged.
  - abort and start together in IDLE: abort wins and nothing starts.
- Operands changing while busy have no effect, because they were latched.

## Timing
- Start is accepted at edge 0. Each slice takes one edge in RUN (edges 1..N).
- done is high during the cycle after edge N: latency N+1 cycles, with 1 ≤ N ≤ S.
- Worst case: A==B or a difference only in the low slice gives N=S (17 cycles for WIDTH=32).
- Early exit: a difference in the top slice gives N=1, so done appears 2 cycles after start.
- busy rises on edge 0 and falls on the edge that ends DONE.
- Back-to-back: earliest next accepted start is the first IDLE cycle after done, giving a throughput of N+2 cycles per compare.
- Reset asserted mid-RUN forces IDLE and reset values immediately (asynchronous). No done follows.

## Test plan
- Reset then idle, WIDTH=8: all outputs 0 and busy=0; start held with reset high → no activity.
- Unsigned WIDTH=8, A=0x5A, B=0x5A: done 5 cycles after start; EQ=1, GT=0, LT=0, slices=4.
- Unsigned WIDTH=8, A=0xC0, B=0x40: top-slice exit; done 2 cycles after start; GT=1, slices=1. Then A=0x12, B=0x13 → LT=1, slices=4.
- SIGNED=1, WIDTH=8, A=0x80 (−128), B=0x7F: LT=1, slices=1. A=0xFF, B=0xFE → GT=1, slices=4.
- start pulsed every cycle while busy, WIDTH=8, A=0x01, B=0x00: exactly one done per accepted start; inputs changed mid-RUN are ignored; GT=1.
- abort on the 2nd RUN cycle of A=B=0xAA: no done, results keep their previous values, busy=0 next cycle. Async reset mid-RUN: outputs 0 within the same cycle.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator: walks two latched operands two bits per
// cycle, exits early once the order is decided, and reports EQ/GT/LT with a done pulse.
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [WIDTH-1:0]                     A,
    input  logic [WIDTH-1:0]                     B,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 EQ,
    output logic                                 GT,
    output logic                                 LT,
    output logic [$clog2(WIDTH/2+1)-1:0]         slices
);

    localparam int unsigned S  = WIDTH / 2;
    localparam int unsigned SW = $clog2(S + 1);
    localparam int unsigned IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              eq_q, eq_d, gt_q, gt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              eq_out_q, eq_out_d, gt_out_q, gt_out_d, lt_out_q, lt_out_d;
    logic [SW-1:0]     slices_q, slices_d;

    logic [1:0]        sa, sb;
    logic              eq_n, gt_n;

    // Current 2-bit slice; the sign bit is flipped so two's-complement orders like unsigned
    always_comb begin
        sa = a_q[{idx_q, 1'b0} +: 2];
        sb = b_q[{idx_q, 1'b0} +: 2];
        if (SIGNED && (idx_q == IW'(S - 1))) begin
            sa[1] = ~sa[1];
            sb[1] = ~sb[1];
        end
        eq_n = eq_q & (sa == sb);
        gt_n = gt_q | (eq_q & (sa > sb));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        eq_out_d = eq_out_q;
        gt_out_d = gt_out_q;
        lt_out_d = lt_out_q;
        slices_d = slices_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    a_d     = A;
                    b_d     = B;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    idx_d   = IW'(S - 1);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    eq_d  = eq_n;
                    gt_d  = gt_n;
                    cnt_d = SW'(cnt_q + SW'(1));
                    if ((idx_q == '0) || !eq_n) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        eq_out_d = eq_n;
                        gt_out_d = gt_n;
                        lt_out_d = ~eq_n & ~gt_n;
                        slices_d = SW'(cnt_q + SW'(1));
                    end else begin
                        idx_d = IW'(idx_q - IW'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            eq_q     <= 1'b1;
            gt_q     <= 1'b0;
            idx_q    <= IW'(S - 1);
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_out_q <= 1'b0;
            gt_out_q <= 1'b0;
            lt_out_q <= 1'b0;
            slices_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            eq_out_q <= eq_out_d;
            gt_out_q <= gt_out_d;
            lt_out_q <= lt_out_d;
            slices_q <= slices_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign EQ     = eq_out_q;
    assign GT     = gt_out_q;
    assign LT     = lt_out_q;
    assign slices = slices_q;

endmodule
